// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receive front end with a first-word-fall-through receive FIFO.
//
// The raw rx pin passes through a two-flop synchroniser. A 16x oversampling tick
// generator drives a receive FSM that recovers bytes LSB-first and pushes each
// good byte into a small FIFO. The core pops the FIFO head with rd_en.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line rate in bit/s
//   FIFO_DEPTH receive FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk       in   system clock, all logic on rising edge
//   rst       in   asynchronous active-high reset
//   rx        in   raw serial line, idle high, asynchronous to clk
//   rd_en     in   pop strobe for the FIFO head, ignored while rd_valid=0
//   ovr_clr   in   clears the sticky overrun flag
//   rd_data   out  FIFO head byte, meaningful only while rd_valid=1
//   rd_valid  out  FIFO not empty
//   frame_err out  one-cycle pulse when a stop bit samples low
//   overrun   out  sticky, set when a good byte arrives while the FIFO is full
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       ovr_clr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overrun
);

  // Oversampling divider: one tick per 1/16 bit time.
  localparam int unsigned Div   = CLK_HZ / (BAUD * 16);
  localparam int unsigned DivW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser (resets to the idle level so reset never looks like a start)
  // ---------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------------
  logic [DivW-1:0] r_div_cnt;
  logic            w_tick;
  logic            w_div_clr;

  assign w_tick = (r_div_cnt == DivW'(Div - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_div_clr || w_tick) begin
      // Clearing on the falling edge aligns all later samples to mid-bit.
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_e  r_state;
  rx_state_e  w_state_nxt;
  logic [3:0] r_tick_cnt;
  logic [3:0] w_tick_cnt_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic       w_push;
  logic       w_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_push         = 1'b0;
    w_ferr         = 1'b0;
    w_div_clr      = 1'b0;

    case (r_state)
      StIdle: begin
        if (!r_rx_s) begin
          w_state_nxt    = StStart;
          w_tick_cnt_nxt = '0;
          w_div_clr      = 1'b1;
        end
      end

      StStart: begin
        if (w_tick) begin
          if (r_tick_cnt == 4'd7) begin
            // Mid start bit: a high line here means the low pulse was a glitch.
            if (r_rx_s) begin
              w_state_nxt = StIdle;
            end else begin
              w_state_nxt    = StData;
              w_tick_cnt_nxt = '0;
              w_bit_idx_nxt  = '0;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      StData: begin
        if (w_tick) begin
          if (r_tick_cnt == 4'd15) begin
            w_shift_nxt    = {r_rx_s, r_shift[7:1]};
            w_tick_cnt_nxt = '0;
            w_bit_idx_nxt  = r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = StStop;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      StStop: begin
        if (w_tick) begin
          if (r_tick_cnt == 4'd15) begin
            w_tick_cnt_nxt = '0;
            if (r_rx_s) begin
              w_push      = 1'b1;
              w_state_nxt = StIdle;
            end else begin
              w_ferr      = 1'b1;
              w_state_nxt = StBreak;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      StBreak: begin
        // Hold here until the line returns high so a long break reports once.
        if (r_rx_s) begin
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_en;
  logic            w_ovr_set;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                   (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
  assign w_pop   = rd_en && !w_empty;
  // A simultaneous pop frees the head slot, so a push while full still fits.
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AddrW-1:0]] <= r_shift;
        r_wr_ptr                   <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  logic r_frame_err;
  logic r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      // A new overrun in the same cycle as a clear keeps the flag set.
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rd_data   = r_mem[r_rd_ptr[AddrW-1:0]];
  assign rd_valid  = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at 64 clk per bit (DIV=4).
// A frame-level model predicts each push/frame error a fixed latency after the
// start edge is driven, and a FIFO queue predicts rd_valid/rd_data/overrun.
module tb_uart_rx_fifo;

  localparam int Depth = 4;
  localparam int Bit   = 64;
  // Clocks from driving the start edge to the edge where the stop sample acts:
  // 2 sync + 1 start detect + 8 ticks * 4 + 9 bits * 64.
  localparam int PushLat = 611;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(
    .CLK_HZ    (1024000),
    .BAUD      (16000),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd_en    (rd_en),
    .ovr_clr  (ovr_clr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int         cyc = 0;
  logic [7:0] m_q[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  int         pend_cyc[$];
  logic [7:0] pend_byte[$];
  logic       pend_good[$];

  function automatic bit due();
    return (pend_cyc.size() != 0) && (pend_cyc[0] == cyc + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      pend_cyc.delete();
      pend_byte.delete();
      pend_good.delete();
      m_ovr  <= 1'b0;
      m_ferr <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      m_ferr <= 1'b0;
      if (ovr_clr) m_ovr <= 1'b0;
      if (due()) begin
        if (rd_en && m_q.size() != 0) void'(m_q.pop_front());
        if (!pend_good[0]) begin
          m_ferr <= 1'b1;
        end else if (m_q.size() < Depth) begin
          m_q.push_back(pend_byte[0]);
        end else begin
          m_ovr <= 1'b1;
        end
        void'(pend_cyc.pop_front());
        void'(pend_byte.pop_front());
        void'(pend_good.pop_front());
      end else if (rd_en && m_q.size() != 0) begin
        void'(m_q.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rd_valid", 8'(rd_valid), 8'h00);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_frame_err", 8'(frame_err), 8'h00);
      chk("rst_overrun", 8'(overrun), 8'h00);
    end else begin
      chk("rd_valid", 8'(rd_valid), 8'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rd_data", rd_data, m_q[0]);
      chk("frame_err", 8'(frame_err), 8'(m_ferr));
      chk("overrun", 8'(overrun), 8'(m_ovr));
      if (frame_err) ferr_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 2000) begin
      tick(1);
      guard++;
    end
    if (cyc < target) begin
      errors++;
      $display("FAIL wait_cyc: reached %0d expected %0d", cyc, target);
    end
  endtask

  // Drives one 8N1 frame; a low stop bit is followed by 5 more low bit times.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    pend_cyc.push_back(cyc + PushLat);
    pend_byte.push_back(b);
    pend_good.push_back(stop);
    rx = 1'b0;
    tick(Bit);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(Bit);
    end
    rx = stop;
    tick(Bit);
    if (!stop) tick(5 * Bit);
    rx = 1'b1;
    tick(16);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, 8'(rd_valid), 8'h01);
    chk(name, rd_data, exp);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c0;
    int f0;
    tick(5);
    rst = 1'b0;
    tick(20);

    // 1: single byte, push latency and pop
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_cyc(c0 + PushLat - 1);
        chk("t1_before_push", 8'(rd_valid), 8'h00);
        tick(1);
        chk("t1_at_push", 8'(rd_valid), 8'h01);
        chk("t1_data", rd_data, 8'hA5);
      end
    join
    pop_expect("t1_pop", 8'hA5);
    chk("t1_empty", 8'(rd_valid), 8'h00);
    rd_en = 1'b1;  // pop while empty: no effect
    tick(1);
    rd_en = 1'b0;
    chk("t1_overrun", 8'(overrun), 8'h00);

    // 2: 20-clk low glitch, then a real frame
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(2 * Bit);
    chk("t2_glitch_nopush", 8'(rd_valid), 8'h00);
    send_frame(8'h3C, 1'b1);
    pop_expect("t2_pop", 8'h3C);

    // 3: framing error followed by a held-low line, then recovery
    f0 = ferr_seen;
    send_frame(8'h55, 1'b0);
    chk("t3_one_ferr", 8'(ferr_seen - f0), 8'h01);
    chk("t3_empty", 8'(rd_valid), 8'h00);
    send_frame(8'h81, 1'b1);
    pop_expect("t3_pop", 8'h81);

    // 4: overflow without reads
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    chk("t4_overrun", 8'(overrun), 8'h01);
    for (int i = 1; i <= 4; i++) pop_expect("t4_pop", 8'(i));
    chk("t4_empty", 8'(rd_valid), 8'h00);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    chk("t4_ovr_clr", 8'(overrun), 8'h00);

    // 5: pop in the same cycle as a push into a full FIFO
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    c0 = cyc;
    fork
      send_frame(8'h05, 1'b1);
      begin
        wait_cyc(c0 + PushLat - 1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
      end
    join
    chk("t5_no_overrun", 8'(overrun), 8'h00);
    for (int i = 2; i <= 5; i++) pop_expect("t5_pop", 8'(i));
    chk("t5_empty", 8'(rd_valid), 8'h00);

    // 6: reset in the middle of data bit 3 (FIFO holds a byte beforehand)
    send_frame(8'h77, 1'b1);
    chk("t6_pre_valid", 8'(rd_valid), 8'h01);
    rx = 1'b0;
    tick(Bit);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1) ? 1'b1 : 1'b0;
      tick(Bit);
    end
    rx = 1'b1;
    tick(Bit / 2);
    rst = 1'b1;
    tick(10);
    chk("t6_rst_valid", 8'(rd_valid), 8'h00);
    tick(5);
    rst = 1'b0;
    tick(100);
    chk("t6_after_rst", 8'(rd_valid), 8'h00);
    send_frame(8'hC3, 1'b1);
    pop_expect("t6_pop", 8'hC3);
    chk("t6_empty", 8'(rd_valid), 8'h00);

    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
